// File: rtl/microondas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microondas_pkg
// Description : Shared types and constants for the microwave timer entry path
// Revision    : 1.0 - initial release
// ============================================================================
package microondas_pkg;

  localparam int DIGIT_W      = 4;
  localparam int MAX_DIGITS   = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_MAX      = 99;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    NORM  = 3'd2,
    LOAD  = 3'd3,
    RUN   = 3'd4
  } state_t;

  // Keypad codes 0-9 are digits; anything above is a function key we ignore
  function automatic logic is_digit(input logic [3:0] code);
    return (code < 4'd10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : time_normalizer
// Description : Combinational mm:ss BCD normalise; seconds tens above 5 are
//               folded into one extra minute, saturating at 99:59
// Revision    : 1.0 - initial release
// ============================================================================
module time_normalizer
  import microondas_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_min_tens,
  input  logic [DIGIT_W-1:0] i_min_ones,
  input  logic [DIGIT_W-1:0] i_sec_tens,
  input  logic [DIGIT_W-1:0] i_sec_ones,
  output logic [DIGIT_W-1:0] o_min_tens,
  output logic [DIGIT_W-1:0] o_min_ones,
  output logic [DIGIT_W-1:0] o_sec_tens,
  output logic [DIGIT_W-1:0] o_sec_ones,
  output logic               o_overflow
);

  localparam bcd_t c_SEC_TENS_MAX = bcd_t'(SEC_TENS_MAX);
  localparam bcd_t c_SEC_WRAP     = bcd_t'(SEC_TENS_MAX + 1);
  localparam bcd_t c_MIN_TENS_MAX = bcd_t'(MIN_MAX / 10);
  localparam bcd_t c_MIN_ONES_MAX = bcd_t'(MIN_MAX % 10);
  localparam bcd_t c_NINE         = bcd_t'(9);

  logic w_sec_over;
  logic w_min_at_max;

  assign w_sec_over   = (i_sec_tens > c_SEC_TENS_MAX);
  assign w_min_at_max = (i_min_tens == c_MIN_TENS_MAX) && (i_min_ones == c_MIN_ONES_MAX);

  // Fold excess seconds into minutes with a BCD carry, or saturate at the top
  always_comb begin
    o_min_tens = i_min_tens;
    o_min_ones = i_min_ones;
    o_sec_tens = i_sec_tens;
    o_sec_ones = i_sec_ones;
    o_overflow = 1'b0;
    if (w_sec_over) begin
      o_overflow = 1'b1;
      if (w_min_at_max) begin
        o_min_tens = c_MIN_TENS_MAX;
        o_min_ones = c_MIN_ONES_MAX;
        o_sec_tens = c_SEC_TENS_MAX;
        o_sec_ones = c_NINE;
      end else begin
        o_sec_tens = i_sec_tens - c_SEC_WRAP;
        if (i_min_ones == c_NINE) begin
          o_min_ones = '0;
          o_min_tens = i_min_tens + bcd_t'(1);
        end else begin
          o_min_ones = i_min_ones + bcd_t'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_entry_loader.sv
`default_nettype none
// ============================================================================
// Module      : time_entry_loader
// Description : Keypad mm:ss entry, normalise, one-cycle loadn into the timer
//               counter chain, then wait for zero or cancel
// Revision    : 1.0 - initial release
// ============================================================================
module time_entry_loader
  import microondas_pkg::*;
(
  input  logic               clk,
  input  logic               clearn,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  input  logic               start,
  input  logic               cancel,
  input  logic               timer_zero,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               loadn,
  output logic               counting,
  output logic               sec_overflow,
  output logic               entry_full
);

  localparam logic [2:0] c_MAX_CNT = 3'(MAX_DIGITS);

  state_t            r_state;
  bcd_t              r_mt, r_mo, r_st, r_so;
  logic [2:0]        r_count;
  logic              r_loadn;
  logic              r_counting;
  logic              r_sec_ovf;
  logic              r_first_run;

  bcd_t              w_n_mt, w_n_mo, w_n_st, w_n_so;
  logic              w_n_ovf;
  logic              w_key_ok;
  logic              w_nonzero;
  logic              w_go_idle;

  time_normalizer u_norm (
    .i_min_tens (r_mt),
    .i_min_ones (r_mo),
    .i_sec_tens (r_st),
    .i_sec_ones (r_so),
    .o_min_tens (w_n_mt),
    .o_min_ones (w_n_mo),
    .o_sec_tens (w_n_st),
    .o_sec_ones (w_n_so),
    .o_overflow (w_n_ovf)
  );

  assign w_key_ok  = key_valid && is_digit(key_code);
  assign w_nonzero = |{r_mt, r_mo, r_st, r_so};

  // Abort back to IDLE: cancel outranks everything; timer_zero is trusted only
  // after the first RUN cycle, since the counters may not show the load yet
  always_comb begin
    w_go_idle = 1'b0;
    if (r_state != IDLE && cancel) begin
      w_go_idle = 1'b1;
    end else if (r_state == RUN && timer_zero && !r_first_run) begin
      w_go_idle = 1'b1;
    end
  end

  // Entry / load / run sequencer with all outputs registered
  always_ff @(posedge clk) begin
    if (!clearn) begin
      r_state     <= IDLE;
      r_mt        <= '0;
      r_mo        <= '0;
      r_st        <= '0;
      r_so        <= '0;
      r_count     <= '0;
      r_loadn     <= 1'b1;
      r_counting  <= 1'b0;
      r_sec_ovf   <= 1'b0;
      r_first_run <= 1'b0;
    end else if (w_go_idle) begin
      r_state     <= IDLE;
      r_mt        <= '0;
      r_mo        <= '0;
      r_st        <= '0;
      r_so        <= '0;
      r_count     <= '0;
      r_loadn     <= 1'b1;
      r_counting  <= 1'b0;
      r_sec_ovf   <= 1'b0;
      r_first_run <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!start && w_key_ok) begin
            r_mt    <= '0;
            r_mo    <= '0;
            r_st    <= '0;
            r_so    <= key_code;
            r_count <= 3'd1;
            r_state <= ENTRY;
          end
        end
        ENTRY: begin
          if (start) begin
            // An all-zero time is not a valid cook request
            if (w_nonzero) begin
              r_state <= NORM;
            end
          end else if (w_key_ok && (r_count < c_MAX_CNT)) begin
            r_mt    <= r_mo;
            r_mo    <= r_st;
            r_st    <= r_so;
            r_so    <= key_code;
            r_count <= r_count + 3'd1;
          end
        end
        NORM: begin
          r_mt      <= w_n_mt;
          r_mo      <= w_n_mo;
          r_st      <= w_n_st;
          r_so      <= w_n_so;
          r_sec_ovf <= r_sec_ovf | w_n_ovf;
          r_loadn   <= 1'b0;
          r_state   <= LOAD;
        end
        LOAD: begin
          r_loadn     <= 1'b1;
          r_counting  <= 1'b1;
          r_first_run <= 1'b1;
          r_state     <= RUN;
        end
        RUN: begin
          r_first_run <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_loadn    <= 1'b1;
          r_counting <= 1'b0;
        end
      endcase
    end
  end

  assign min_tens     = r_mt;
  assign min_ones     = r_mo;
  assign sec_tens     = r_st;
  assign sec_ones     = r_so;
  assign loadn        = r_loadn;
  assign counting     = r_counting;
  assign sec_overflow = r_sec_ovf;
  assign entry_full   = (r_count == c_MAX_CNT);

endmodule
`default_nettype wire
